// File: rtl/fp_pow_int.sv
// Iterative IEEE-754 single-precision integer power (base^n, signed n), square-and-multiply LSB first.
// Optional macro FP_POW_RECIP_EN adds a final 1.0/x step for negative n; without it negative n sets err.
module fp_pow_int #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [EXP_W-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             err
);

  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    SQUARE,
`ifdef FP_POW_RECIP_EN
    RECIP,
`endif
    DONE
  } state_t;

  state_t           state, state_next;
  logic [31:0]      acc, acc_next;
  logic [31:0]      sq, sq_next;
  logic [EXP_W-1:0] mag, mag_next;
  logic             neg, neg_next;
  logic             err_next;
  logic [EXP_W-1:0] n_abs;
  logic [31:0]      mul_a, mul_b, mul_out;

  // Single-precision multiply, round-to-nearest-even; subnormals are flushed to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [7:0]         ea, eb;
    logic [23:0]        am, bm;
    logic [47:0]        p;
    logic [22:0]        m;
    logic               g, st, rnd;
    logic [23:0]        mr;
    logic signed [9:0]  e;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (&ea) && (|a[22:0]);
    b_nan  = (&eb) && (|b[22:0]);
    a_inf  = (&ea) && !(|a[22:0]);
    b_inf  = (&eb) && !(|b[22:0]);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    am     = {1'b1, a[22:0]};
    bm     = {1'b1, b[22:0]};
    p      = {24'd0, am} * {24'd0, bm};
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
      e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    end
    rnd = g & (st | m[0]);
    mr  = {1'b0, m} + {23'd0, rnd};
    if (mr[23]) e = e + 10'sd1;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
    else if (a_inf || b_inf)   return {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero) return {s, 31'd0};
    else if (e >= 10'sd255)    return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)      return {s, 31'd0};
    else                       return {s, e[7:0], mr[22:0]};
  endfunction

`ifdef FP_POW_RECIP_EN
  // Single-precision 1.0/x: quotient 2^49 / mantissa gives 26-27 significant bits plus a remainder for sticky.
  function automatic logic [31:0] fp_recip(input logic [31:0] x);
    logic               s;
    logic [7:0]         ex;
    logic [49:0]        num, den;
    logic [26:0]        q;
    logic               rem_nz, rnd;
    logic [23:0]        mr;
    logic signed [9:0]  e;
    s      = x[31];
    ex     = x[30:23];
    num    = 50'd1 << 49;
    den    = {26'd0, 1'b1, x[22:0]};
    q      = 27'(num / den);
    rem_nz = ((num % den) != 50'd0);
    e      = 10'sd253 - $signed({2'b00, ex});
    if (q[26]) begin
      mr = 24'd0;
      e  = e + 10'sd1;
    end else begin
      rnd = q[1] & (q[0] | rem_nz | q[2]);
      mr  = {1'b0, q[24:2]} + {23'd0, rnd};
      if (mr[23]) e = e + 10'sd1;
    end
    if ((&ex) && (|x[22:0]))  return 32'h7FC00000;
    else if (&ex)             return {s, 31'd0};
    else if (ex == 8'd0)      return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)     return {s, 31'd0};
    else                      return {s, e[7:0], mr[22:0]};
  endfunction
`endif

  assign n_abs   = n[EXP_W-1] ? (~n + EXP_W'(1)) : n;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign mul_out = fp_mul(mul_a, mul_b);

  // The one multiplier serves acc*sq in MULT and sq*sq in SQUARE.
  always_comb begin
    mul_a = acc;
    mul_b = sq;
    if (state == SQUARE) mul_a = sq;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    sq_next    = sq;
    mag_next   = mag;
    neg_next   = neg;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next   = FP_ONE;
          sq_next    = base;
          mag_next   = n_abs;
          neg_next   = n[EXP_W-1];
          state_next = (n_abs == '0) ? DONE : MULT;
        end
      end
      MULT: begin
        if (mag[0]) acc_next = mul_out;
        if (mag == EXP_W'(1)) begin
`ifdef FP_POW_RECIP_EN
          state_next = neg ? RECIP : DONE;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = SQUARE;
        end
      end
      SQUARE: begin
        sq_next    = mul_out;
        mag_next   = mag >> 1;
        state_next = MULT;
      end
`ifdef FP_POW_RECIP_EN
      RECIP: begin
        acc_next   = fp_recip(acc);
        state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef FP_POW_RECIP_EN
  assign err_next = 1'b0;
`else
  assign err_next = neg_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= 32'h0;
      sq     <= 32'h0;
      mag    <= '0;
      neg    <= 1'b0;
      result <= 32'h0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      sq    <= sq_next;
      mag   <= mag_next;
      neg   <= neg_next;
      // result/err are captured on the edge that enters DONE, from the value acc is about to take.
      if (state_next == DONE) begin
        result <= acc_next;
        err    <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_pow_int.sv
// Self-checking bench for fp_pow_int: directed vectors with literal expectations plus a
// real-arithmetic reference model compared against the outputs every cycle.
module tb_fp_pow_int;

  localparam int EXP_W = 8;
`ifdef FP_POW_RECIP_EN
  localparam bit RECIP_EN = 1'b1;
`else
  localparam bit RECIP_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      base;
  logic [EXP_W-1:0] n;
  logic             busy;
  logic             done;
  logic [31:0]      result;
  logic             err;

  int compared   = 0;
  int mismatched = 0;

  fp_pow_int #(.EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .n(n),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", what, actual, expected, $time);
    end
  endtask

  function automatic real bitsToReal(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (e > 0) repeat (e) v = v * 2.0;
    else       repeat (-e) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] realToBits(input real v);
    logic   s;
    real    a;
    int     e;
    longint mnt;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a == 0.0) return {s, 31'd0};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e > 127)  return {s, 8'hFF, 23'd0};
    if (e < -126) return {s, 31'd0};
    mnt = longint'((a - 1.0) * 8388608.0);
    return {s, 8'(e + 127), mnt[22:0]};
  endfunction

  // Reference: plain repeated multiplication in double, optional reciprocal, then rounding to single.
  function automatic logic [31:0] modelResult(input logic [31:0] b, input int nv);
    real r, bv;
    int  m;
    bv = bitsToReal(b);
    m  = (nv < 0) ? -nv : nv;
    r  = 1.0;
    repeat (m) r = r * bv;
    if (nv < 0 && RECIP_EN) r = 1.0 / r;
    return realToBits(r);
  endfunction

  function automatic int modelLatency(input int nv);
    int m;
    m = (nv < 0) ? -nv : nv;
    if (m == 0) return 1;
    return 2 * $clog2(m + 1) + ((nv < 0 && RECIP_EN) ? 1 : 0);
  endfunction

  // Monitor: track accepted starts and compare busy/done every cycle, result/err on done.
  initial begin
    logic             s_start, s_busy;
    logic [31:0]      s_base;
    logic [EXP_W-1:0] s_n;
    bit               act;
    int               cnt, lat;
    logic [31:0]      exp_res;
    logic             exp_err, exp_done;
    act = 0; cnt = 0; lat = 0; exp_res = 0; exp_err = 0;
    forever begin
      @(negedge clk); #1;
      s_start = start; s_busy = busy; s_base = base; s_n = n;
      @(posedge clk); #1;
      if (!rst_n) begin
        act = 0;
        checkOutput("mon_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mon_rst_done", {31'd0, done}, 32'd0);
        checkOutput("mon_rst_err", {31'd0, err}, 32'd0);
        checkOutput("mon_rst_result", result, 32'd0);
      end else begin
        if (act) begin
          cnt++;
        end else if (s_start && !s_busy) begin
          act     = 1;
          cnt     = 1;
          lat     = modelLatency(int'($signed(s_n)));
          exp_res = modelResult(s_base, int'($signed(s_n)));
          exp_err = ($signed(s_n) < 0) && !RECIP_EN;
        end
        exp_done = act && (cnt == lat);
        checkOutput("mon_busy", {31'd0, busy}, {31'd0, act});
        checkOutput("mon_done", {31'd0, done}, {31'd0, exp_done});
        if (exp_done) begin
          checkOutput("mon_result", result, exp_res);
          checkOutput("mon_err", {31'd0, err}, {31'd0, exp_err});
          act = 0;
        end
      end
    end
  end

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    if (busy) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] b, input logic signed [EXP_W-1:0] e,
                               input logic [31:0] expRes, input logic expErr, input int expLat);
    int cyc;
    bit got;
    waitIdle();
    base = b; n = e; start = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done) got = 1;
    end
    if (!got) begin
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, "_latency"}, 32'(cyc), 32'(expLat));
      checkOutput({name, "_result"}, result, expRes);
      checkOutput({name, "_err"}, {31'd0, err}, {31'd0, expErr});
    end
  endtask

  initial begin
    int dones;
    logic [31:0] lastRes;
    rst_n = 1'b0; start = 1'b0; base = 32'h0; n = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("two_cubed", 32'h40000000, 8'sd3, 32'h41000000, 1'b0, 4);
    applyStimulus("onehalf_pow10", 32'h3FC00000, 8'sd10, 32'h4266A900, 1'b0, 8);
    applyStimulus("three_pow0", 32'h40400000, 8'sd0, 32'h3F800000, 1'b0, 1);
`ifdef FP_POW_RECIP_EN
    applyStimulus("four_neg2", 32'h40800000, -8'sd2, 32'h3D800000, 1'b0, 5);
    applyStimulus("two_neg126", 32'h40000000, -8'sd126, 32'h00800000, 1'b0, 15);
    applyStimulus("one_neg128", 32'h3F800000, -8'sd128, 32'h3F800000, 1'b0, 17);
`else
    applyStimulus("four_neg2", 32'h40800000, -8'sd2, 32'h41800000, 1'b1, 4);
    applyStimulus("two_neg126", 32'h40000000, -8'sd126, 32'h7E800000, 1'b1, 14);
    applyStimulus("one_neg128", 32'h3F800000, -8'sd128, 32'h3F800000, 1'b1, 16);
`endif
    applyStimulus("negtwo_cubed", 32'hC0000000, 8'sd3, 32'hC1000000, 1'b0, 4);
    applyStimulus("three_pow5", 32'h40400000, 8'sd5, 32'h43730000, 1'b0, 6);
    applyStimulus("half_pow5", 32'h3F000000, 8'sd5, 32'h3D000000, 1'b0, 6);
    applyStimulus("onequarter_pow7", 32'h3FA00000, 8'sd7, 32'h40989680, 1'b0, 6);
    applyStimulus("two_pow1", 32'h40000000, 8'sd1, 32'h40000000, 1'b0, 2);
    applyStimulus("two_pow127", 32'h40000000, 8'sd127, 32'h7F000000, 1'b0, 14);
    applyStimulus("negone_pow127", 32'hBF800000, 8'sd127, 32'hBF800000, 1'b0, 14);

    // start held high through a run, with a second request injected two cycles in
    waitIdle();
    base = 32'h40000000; n = 8'sd3; start = 1'b1;
    dones = 0; lastRes = 32'h0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin base = 32'h40400000; n = 8'sd5; end
      if (c == 4) start = 1'b0;
      if (done) begin dones++; lastRes = result; end
    end
    checkOutput("held_start_done_count", 32'(dones), 32'd1);
    checkOutput("held_start_result", lastRes, 32'h41000000);

    // reset asserted while the block sits in SQUARE
    waitIdle();
    base = 32'h40000000; n = 8'sd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrun_rst_done", {31'd0, done}, 32'd0);
    checkOutput("midrun_rst_err", {31'd0, err}, 32'd0);
    checkOutput("midrun_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("after_reset", 32'h40000000, 8'sd3, 32'h41000000, 1'b0, 4);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
